seg7_capture: RTL and testbench
===============================

Name: seg7_capture

Overview:
- Receive-side counterpart of the hex-counter seven-segment driver: samples an external 7-bit segment bus, filters glitches, and decodes the pattern back to a 4-bit hex digit.
- Checks that successive digits follow the +1 mod 16 counting sequence.
- Measures the number of clock cycles between digit changes.
- Sits behind the dedicated input pins. Used to verify a second board's display output, or for loopback of our own counter.

Parameters:
- SYNC_STAGES, 2, number of input synchronizer flops (minimum 2).
- STABLE_CYCLES, 4, consecutive identical synchronized samples required before a pattern is accepted (minimum 1).
- PERIOD_W, 24, width of the period measurement counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- seg_in  in  7  segment bus {g,f,e,d,c,b,a}, bit0 = a, active-high, asynchronous to clk.
- clear  in  1  synchronous clear of seq_error, change_count and period state.
- digit  out  4  last accepted valid digit.
- digit_valid  out  1  digit holds a decoded value; low when blank or after reset.
- new_digit  out  1  one-cycle pulse when a new valid digit is accepted.
- invalid  out  1  one-cycle pulse when a non-blank, non-hex pattern is accepted.
- seq_error  out  1  sticky: a sequence violation was seen.
- period  out  PERIOD_W  cycles between the last two new_digit pulses.
- period_valid  out  1  period holds a real measurement.
- change_count  out  8  count of new_digit pulses, wraps 255 -> 0.

Behaviour:
- Interface decided: one clock, clk; rst is asynchronous, active-high.
- Reset values: all outputs 0; synchronizer and accepted-pattern register 7'h00; FSM in IDLE.
- Synchronizer: SYNC_STAGES flops on seg_in; no logic between them.
- Stability filter:
  - Counter resets to 0 whenever the synchronized sample differs from the previous sample, and increments otherwise.
  - A pattern is accepted when STABLE_CYCLES identical samples have been seen and it differs from the currently accepted pattern.
  - Re-acceptance of an unchanged pattern never occurs.
- Latency: new_digit / invalid assert exactly SYNC_STAGES + STABLE_CYCLES rising edges after the first edge sampling the new seg_in value, provided seg_in is held constant.
- Glitch rule: a pattern held fewer than STABLE_CYCLES synchronized cycles is ignored entirely.
- Decode table (hex):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - 00 = blank; any other pattern = invalid.
- On an accepted valid pattern:
  - digit updates and digit_valid = 1.
  - new_digit pulses for one cycle.
  - change_count increments.
- On an accepted blank pattern: digit_valid = 0, digit holds its value, no pulse, FSM -> IDLE.
- On an accepted invalid pattern: invalid pulses, digit / digit_valid hold, FSM unchanged.
- FSM:
  - IDLE: no reference digit.
  - TRACK: one reference digit, period not yet measured.
  - LOCKED: period measured.
- Transitions:
  - IDLE -valid-> TRACK.
  - TRACK -valid-> LOCKED, with period latched and period_valid = 1.
  - LOCKED -valid-> LOCKED, with period re-latched.
  - Any state -blank or clear-> IDLE.
- Sequence check: in TRACK or LOCKED, a valid digit != (previous digit + 1) mod 16 sets seq_error. The wrap F -> 0 is legal. The period measurement still updates on a violation.
- Period counter:
  - Counts clk cycles since the last new_digit and saturates at all-ones (no wrap).
  - On new_digit, period = counter value, then the counter restarts at 1 on the next cycle.
  - Resulting definition: the value latched equals the number of edges between the two pulses.
- clear:
  - Zeroes seq_error, change_count, period and period_valid; FSM -> IDLE.
  - digit and digit_valid are kept.
  - If clear and an acceptance coincide, clear wins for the counters and FSM, and the accepted digit is still loaded. The FSM then goes to TRACK instead of IDLE.
- rst mid-operation: immediate return to reset values; the synchronizer flushes.

Decomposition:
- Shared package seg7_pkg:
  - Segment constants SEG_0..SEG_F and SEG_BLANK.
  - FSM state typedef (IDLE/TRACK/LOCKED).
  - Decode function seg7_decode returning {valid, blank, digit}.
- One natural sub-module: seg7_stable_filter, containing the synchronizer, stability counter, accepted-pattern register and accept strobe.

Test Plan:
- Hold seg_in=3F from reset, STABLE_CYCLES=4 -> new_digit at edge 6, digit=0, digit_valid=1, change_count=1, seq_error=0.
- Sequence 06 then 5B, each held 100 cycles -> digits 1 then 2; second pulse gives period=100, period_valid=1; seq_error stays 0.
- 3F held, 3-cycle glitch to 7F, back to 3F -> no new_digit, no invalid, digit stays 0.
- Digit 7 (07) followed by 66 (4) -> new_digit, digit=4, seq_error=1; sticky until clear=1, then seq_error=0, change_count=0, period_valid=0.
- Accept 71 (F) then 3F (0) -> no seq_error (legal wrap). Then 12 (invalid) -> invalid pulse, digit stays 0. Then 00 -> digit_valid=0, FSM IDLE, and the next 4F is accepted with no seq check.
- Hold one valid digit for more than 2^24 cycles with PERIOD_W=24, then advance -> period=FFFFFF (saturated). Assert rst mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment capture block:
// segment codes, tracking states and the pattern decoder.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_A     = 7'h77;
   localparam logic [6:0] SEG_B     = 7'h7C;
   localparam logic [6:0] SEG_C     = 7'h39;
   localparam logic [6:0] SEG_D     = 7'h5E;
   localparam logic [6:0] SEG_E     = 7'h79;
   localparam logic [6:0] SEG_F     = 7'h71;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   typedef struct packed {
      logic       valid;
      logic       blank;
      logic [3:0] digit;
   } dec_t;

   function automatic dec_t seg7_decode(input logic [6:0] seg);
      dec_t d;
      d = '0;
      d.valid = 1'b1;
      case (seg)
         SEG_0:     d.digit = 4'h0;
         SEG_1:     d.digit = 4'h1;
         SEG_2:     d.digit = 4'h2;
         SEG_3:     d.digit = 4'h3;
         SEG_4:     d.digit = 4'h4;
         SEG_5:     d.digit = 4'h5;
         SEG_6:     d.digit = 4'h6;
         SEG_7:     d.digit = 4'h7;
         SEG_8:     d.digit = 4'h8;
         SEG_9:     d.digit = 4'h9;
         SEG_A:     d.digit = 4'hA;
         SEG_B:     d.digit = 4'hB;
         SEG_C:     d.digit = 4'hC;
         SEG_D:     d.digit = 4'hD;
         SEG_E:     d.digit = 4'hE;
         SEG_F:     d.digit = 4'hF;
         SEG_BLANK: begin
            d.valid = 1'b0;
            d.blank = 1'b1;
         end
         default:   d.valid = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// Synchronizes the asynchronous segment bus and accepts a pattern
// once it has been seen unchanged for STABLE_CYCLES samples.
module seg7_stable_filter
   import seg7_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] seg_in,
   output logic [6:0] sample,
   output logic       accept
);

   // cnt counts repeats of prev, so a run of K equal samples
   // is reached when cnt hits K-2 and the current sample matches.
   localparam int CW =
      (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CW-1:0] THR =
      CW'((STABLE_CYCLES > 2) ? STABLE_CYCLES - 2 : 0);

   logic [SYNC_STAGES-1:0][6:0] sync_q;
   logic [6:0]                  prev;
   logic [6:0]                  held;
   logic [CW-1:0]               cnt;
   logic                        same;
   logic                        stable;

   assign sample = sync_q[SYNC_STAGES-1];
   assign same   = (sample == prev);
   assign stable = (STABLE_CYCLES <= 1) || (same && (cnt >= THR));
   assign accept = stable && (sample != held);

   // Plain flop chain: no logic between synchronizer stages.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], seg_in};
      end
   end

   // Run-length counter and the currently accepted pattern.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev <= SEG_BLANK;
         cnt  <= '0;
         held <= SEG_BLANK;
      end else begin
         prev <= sample;
         if (!same) begin
            cnt <= '0;
         end else if (cnt != THR) begin
            cnt <= cnt + 1'b1;
         end
         if (accept) begin
            held <= sample;
         end
      end
   end

endmodule

// File: rtl/seg7_capture.sv
// Decodes a captured seven-segment bus back to hex, checks the
// +1 counting sequence and measures cycles between digit changes.
module seg7_capture
   import seg7_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4,
   parameter int PERIOD_W      = 24
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [6:0]          seg_in,
   input  logic                clear,
   output logic [3:0]          digit,
   output logic                digit_valid,
   output logic                new_digit,
   output logic                invalid,
   output logic                seq_error,
   output logic [PERIOD_W-1:0] period,
   output logic                period_valid,
   output logic [7:0]          change_count
);

   logic [6:0]          sample;
   logic                accept;
   dec_t                dec;
   logic                acc_valid;
   logic                acc_blank;
   logic                acc_bad;
   state_t              state;
   state_t              state_next;
   logic                latch_period;
   logic                check_seq;
   logic                seq_bad;
   logic [PERIOD_W-1:0] pcnt;

   seg7_stable_filter #(
      .SYNC_STAGES   (SYNC_STAGES),
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_filter (
      .clk    (clk),
      .rst    (rst),
      .seg_in (seg_in),
      .sample (sample),
      .accept (accept)
   );

   assign dec       = seg7_decode(sample);
   assign acc_valid = accept && dec.valid;
   assign acc_blank = accept && dec.blank;
   assign acc_bad   = accept && !dec.valid && !dec.blank;
   assign seq_bad   = check_seq && (dec.digit != digit + 4'd1);

   // Tracking state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state; clear overrides, but a coinciding digit
   // still becomes the new reference.
   always_comb begin
      state_next   = state;
      latch_period = 1'b0;
      check_seq    = 1'b0;
      if (acc_valid) begin
         case (state)
            IDLE: state_next = TRACK;
            TRACK, LOCKED: begin
               state_next   = LOCKED;
               latch_period = 1'b1;
               check_seq    = 1'b1;
            end
            default: state_next = IDLE;
         endcase
      end else if (acc_blank) begin
         state_next = IDLE;
      end
      if (clear) begin
         state_next   = acc_valid ? TRACK : IDLE;
         latch_period = 1'b0;
         check_seq    = 1'b0;
      end
   end

   // Digit register and acceptance pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digit       <= 4'h0;
         digit_valid <= 1'b0;
         new_digit   <= 1'b0;
         invalid     <= 1'b0;
      end else begin
         new_digit <= acc_valid;
         invalid   <= acc_bad;
         if (acc_valid) begin
            digit       <= dec.digit;
            digit_valid <= 1'b1;
         end else if (acc_blank) begin
            digit_valid <= 1'b0;
         end
      end
   end

   // Period counter restarts at each new digit and saturates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt <= '0;
      end else if (acc_valid) begin
         pcnt <= {{(PERIOD_W-1){1'b0}}, 1'b1};
      end else if (clear) begin
         pcnt <= '0;
      end else if (pcnt != '1) begin
         pcnt <= pcnt + 1'b1;
      end
   end

   // Statistics: sticky error, change count, latched period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seq_error    <= 1'b0;
         change_count <= 8'd0;
         period       <= '0;
         period_valid <= 1'b0;
      end else if (clear) begin
         seq_error    <= 1'b0;
         change_count <= 8'd0;
         period       <= '0;
         period_valid <= 1'b0;
      end else begin
         if (seq_bad) begin
            seq_error <= 1'b1;
         end
         if (acc_valid) begin
            change_count <= change_count + 8'd1;
         end
         if (latch_period) begin
            period       <= pcnt;
            period_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: a window/time-difference reference
// model checked every cycle plus hand-computed expectations.
module tb_seg7_capture;

   localparam int SYNC = 2;
   localparam int STAB = 4;
   localparam int MAX24 = 16777215;
   localparam int MAX8 = 255;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  seg_in;
   logic        clear;

   logic [3:0]  digit, digit_s;
   logic        digit_valid, digit_valid_s;
   logic        new_digit, new_digit_s;
   logic        invalid, invalid_s;
   logic        seq_error, seq_error_s;
   logic [23:0] period;
   logic [7:0]  period_s;
   logic        period_valid, period_valid_s;
   logic [7:0]  change_count, change_count_s;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   seg7_capture dut (
      .clk          (clk),
      .rst          (rst),
      .seg_in       (seg_in),
      .clear        (clear),
      .digit        (digit),
      .digit_valid  (digit_valid),
      .new_digit    (new_digit),
      .invalid      (invalid),
      .seq_error    (seq_error),
      .period       (period),
      .period_valid (period_valid),
      .change_count (change_count)
   );

   seg7_capture #(.PERIOD_W(8)) dut_s (
      .clk          (clk),
      .rst          (rst),
      .seg_in       (seg_in),
      .clear        (clear),
      .digit        (digit_s),
      .digit_valid  (digit_valid_s),
      .new_digit    (new_digit_s),
      .invalid      (invalid_s),
      .seq_error    (seq_error_s),
      .period       (period_s),
      .period_valid (period_valid_s),
      .change_count (change_count_s)
   );

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Reference model: a pattern is accepted once the K samples
   // that have cleared the synchronizer are all equal.
   logic [6:0] segtab [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };
   logic [6:0] hist [$];
   logic [6:0] m_acc, pat;
   int m_digit, m_dv, m_new, m_inv, m_seq;
   int m_per, m_per_s, m_pv, m_cc, m_refs, m_last, now;
   int idx, gap, viol, stable;

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         hist.delete();
         for (int i = 0; i < SYNC + STAB; i++) hist.push_back(7'h00);
         m_acc = 7'h00;
         m_digit = 0; m_dv = 0; m_new = 0; m_inv = 0; m_seq = 0;
         m_per = 0; m_per_s = 0; m_pv = 0; m_cc = 0;
         m_refs = 0; m_last = 0; now = 0;
      end else begin
         now++;
         hist.push_back(seg_in);
         void'(hist.pop_front());
         m_new = 0;
         m_inv = 0;
         viol = 0;
         pat = hist[0];
         stable = 1;
         for (int i = 1; i < STAB; i++)
            if (hist[i] != pat) stable = 0;
         if (stable != 0 && pat != m_acc) begin
            m_acc = pat;
            idx = -1;
            for (int d = 0; d < 16; d++)
               if (segtab[d] == pat) idx = d;
            if (idx >= 0) begin
               m_new = 1;
               if (m_refs > 0) begin
                  if (idx != (m_digit + 1) % 16) viol = 1;
                  gap = now - m_last;
                  m_per = (gap > MAX24) ? MAX24 : gap;
                  m_per_s = (gap > MAX8) ? MAX8 : gap;
                  m_pv = 1;
               end
               m_refs = (m_refs == 0) ? 1 : 2;
               m_last = now;
               m_digit = idx;
               m_dv = 1;
               m_cc = (m_cc + 1) % 256;
            end else if (pat == 7'h00) begin
               m_dv = 0;
               m_refs = 0;
            end else begin
               m_inv = 1;
            end
         end
         if (clear) begin
            m_seq = 0; m_cc = 0; m_per = 0; m_per_s = 0; m_pv = 0;
            m_refs = m_new;
         end else if (viol != 0) begin
            m_seq = 1;
         end
      end
   end

   // Every-cycle comparison of both instances against the model.
   initial forever begin
      @(negedge clk);
      check("digit", 32'(digit), m_digit);
      check("digit_valid", 32'(digit_valid), m_dv);
      check("new_digit", 32'(new_digit), m_new);
      check("invalid", 32'(invalid), m_inv);
      check("seq_error", 32'(seq_error), m_seq);
      check("period", 32'(period), m_per);
      check("period_valid", 32'(period_valid), m_pv);
      check("change_count", 32'(change_count), m_cc);
      check("s.digit", 32'(digit_s), m_digit);
      check("s.digit_valid", 32'(digit_valid_s), m_dv);
      check("s.new_digit", 32'(new_digit_s), m_new);
      check("s.invalid", 32'(invalid_s), m_inv);
      check("s.seq_error", 32'(seq_error_s), m_seq);
      check("s.period", 32'(period_s), m_per_s);
      check("s.period_valid", 32'(period_valid_s), m_pv);
      check("s.change_count", 32'(change_count_s), m_cc);
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int found;

   initial begin
      rst = 1'b1;
      seg_in = 7'h3F;
      clear = 1'b0;
      step(3);
      check("rst digit", 32'(digit), 0);
      check("rst digit_valid", 32'(digit_valid), 0);
      check("rst change_count", 32'(change_count), 0);
      check("rst period_valid", 32'(period_valid), 0);
      rst = 1'b0;

      found = 0;
      for (int i = 1; i <= 20 && found == 0; i++) begin
         step(1);
         if (new_digit) found = i;
      end
      check("first latency", found, 6);
      check("first digit", 32'(digit), 0);
      check("first digit_valid", 32'(digit_valid), 1);
      check("first change_count", 32'(change_count), 1);
      check("first seq_error", 32'(seq_error), 0);

      step(20);
      seg_in = 7'h06;
      step(100);
      seg_in = 7'h5B;
      step(100);
      check("seq12 digit", 32'(digit), 2);
      check("seq12 period", 32'(period), 100);
      check("seq12 period_valid", 32'(period_valid), 1);
      check("seq12 change_count", 32'(change_count), 3);
      check("seq12 seq_error", 32'(seq_error), 0);

      seg_in = 7'h7F;
      step(3);
      seg_in = 7'h5B;
      step(20);
      seg_in = 7'h12;
      step(3);
      seg_in = 7'h5B;
      step(20);
      check("glitch digit", 32'(digit), 2);
      check("glitch change_count", 32'(change_count), 3);

      seg_in = 7'h00;
      step(20);
      check("blank digit_valid", 32'(digit_valid), 0);
      check("blank digit held", 32'(digit), 2);
      seg_in = 7'h07;
      step(20);
      check("after blank seq_error", 32'(seq_error), 0);
      seg_in = 7'h66;
      step(20);
      check("7to4 digit", 32'(digit), 4);
      check("7to4 seq_error", 32'(seq_error), 1);
      step(10);
      check("seq_error sticky", 32'(seq_error), 1);
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      check("clear seq_error", 32'(seq_error), 0);
      check("clear change_count", 32'(change_count), 0);
      check("clear period_valid", 32'(period_valid), 0);
      check("clear keeps digit", 32'(digit), 4);
      check("clear keeps valid", 32'(digit_valid), 1);

      seg_in = 7'h71;
      step(20);
      seg_in = 7'h3F;
      step(20);
      check("wrap digit", 32'(digit), 0);
      check("wrap seq_error", 32'(seq_error), 0);
      seg_in = 7'h12;
      found = 0;
      for (int i = 1; i <= 20 && found == 0; i++) begin
         step(1);
         if (invalid) found = i;
      end
      check("invalid latency", found, 6);
      check("invalid keeps digit", 32'(digit), 0);
      check("invalid keeps valid", 32'(digit_valid), 1);
      step(10);
      seg_in = 7'h00;
      step(20);
      check("blank2 digit_valid", 32'(digit_valid), 0);
      seg_in = 7'h4F;
      step(20);
      check("idle digit", 32'(digit), 3);
      check("idle no seq check", 32'(seq_error), 0);

      seg_in = 7'h66;
      step(5);
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      check("clr+acc new_digit", 32'(new_digit), 1);
      check("clr+acc digit", 32'(digit), 4);
      check("clr+acc change_count", 32'(change_count), 0);
      step(44);
      seg_in = 7'h6D;
      step(20);
      check("clr+acc period", 32'(period), 50);
      check("clr+acc period_valid", 32'(period_valid), 1);
      check("clr+acc count", 32'(change_count), 1);

      step(280);
      seg_in = 7'h7D;
      step(20);
      check("long period 24b", 32'(period), 300);
      check("sat period 8b", 32'(period_s), 255);
      check("long digit", 32'(digit), 6);
      check("long seq_error", 32'(seq_error), 0);

      #3;
      rst = 1'b1;
      #1;
      check("async rst digit", 32'(digit), 0);
      check("async rst valid", 32'(digit_valid), 0);
      check("async rst period", 32'(period), 0);
      check("async rst count", 32'(change_count), 0);
      check("async rst pv", 32'(period_valid), 0);
      step(3);
      rst = 1'b0;
      step(20);
      check("post rst digit", 32'(digit), 6);
      check("post rst count", 32'(change_count), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
